// File: rtl/chu_pwm_fade_ctrl.sv
// PWM fade controller: ramps each channel's duty toward its target on every interval tick
// and forwards divisor writes to the PWM core. Optional macro: PWM_FADE_READBACK_EN.

module chu_pwm_fade_ctrl #(
   parameter int W = 6,
   parameter int R = 10
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        cs,
   input  logic        read,
   input  logic        write,
   input  logic [4:0]  addr,
   input  logic [31:0] wr_data,
   output logic [31:0] rd_data,
   output logic        m_cs,
   output logic        m_write,
   output logic [4:0]  m_addr,
   output logic [31:0] m_wr_data
);

   localparam int DW  = R + 1;
   localparam int AW  = (R + 2 > 10) ? R + 2 : 10;
   localparam int CHW = (W > 1) ? $clog2(W) : 1;
   localparam logic [R:0]     DUTY_MAX = {1'b1, {R{1'b0}}};
   localparam logic [CHW-1:0] LAST_CH  = CHW'(W - 1);

   typedef enum logic {IDLE, SCAN} state_t;

   function automatic logic [R:0] sat_duty(input logic [31:0] d);
      sat_duty = (d[R:0] > DUTY_MAX) ? DUTY_MAX : d[R:0];
   endfunction

   // Distance-based compare lands exactly on the target instead of overshooting it.
   function automatic logic [R:0] ramp_step(input logic [R:0] cur, input logic [R:0] tgt,
                                            input logic [7:0] step);
      logic [AW-1:0] c, t, s;
      c = AW'(cur);
      t = AW'(tgt);
      s = (step == 8'd0) ? AW'(1) : AW'(step);
      ramp_step = cur;
      if (c < t)      ramp_step = ((t - c) <= s) ? tgt : DW'(c + s);
      else if (c > t) ramp_step = ((c - t) <= s) ? tgt : DW'(c - s);
   endfunction

   state_t         state_q, state_d;
   logic [CHW-1:0] ch_q, ch_d;
   logic [31:0]    div_q, div_d;
   logic           en_q, en_d;
   logic [23:0]    rate_q, rate_d;
   logic           ovr_q, ovr_d;
   logic [15:0]    cnt_q, cnt_d;
   logic [R:0]     cur_q [W];
   logic [R:0]     cur_d [W];
   logic [R:0]     tgt_q [W];
   logic [R:0]     tgt_d [W];
   logic           m_cs_q, m_cs_d;
   logic [4:0]     m_addr_q, m_addr_d;
   logic [31:0]    m_data_q, m_data_d;

   logic           wr_en, fwd, tick, upd, busy;
   logic [15:0]    interval;
   logic [7:0]     step;
   logic [R:0]     cur_sel, tgt_sel, cur_new;

   always_comb begin
      wr_en    = cs & write;
      fwd      = wr_en & (addr == 5'h00);
      interval = rate_q[15:0];
      step     = rate_q[23:16];
      tick     = en_q & (cnt_q == interval);
      cnt_d    = en_q ? ((cnt_q == interval) ? 16'd0 : cnt_q + 16'd1) : 16'd0;
      div_d    = fwd ? wr_data : div_q;
      en_d     = en_q;
      rate_d   = rate_q;
      ovr_d    = ovr_q;
      if (wr_en && addr == 5'h01) begin
         en_d = wr_data[0];
         if (wr_data[2]) ovr_d = 1'b0;
      end
      if (wr_en && addr == 5'h02) rate_d = wr_data[23:0];
      // A tick during a pass is dropped; flagging it wins over a same-cycle clear.
      if (tick && state_q == SCAN) ovr_d = 1'b1;
      for (int i = 0; i < W; i++) begin
         tgt_d[i] = tgt_q[i];
         if (wr_en && addr == 5'(16 + i)) tgt_d[i] = sat_duty(wr_data);
      end
   end

   always_comb begin
      cur_sel = '0;
      tgt_sel = '0;
      busy    = 1'b0;
      for (int i = 0; i < W; i++) begin
         if (ch_q == CHW'(i)) begin
            cur_sel = cur_q[i];
            tgt_sel = tgt_q[i];
         end
         if (cur_q[i] != tgt_q[i]) busy = 1'b1;
      end
   end

   // FSM: state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         ch_q    <= '0;
      end else begin
         state_q <= state_d;
         ch_q    <= ch_d;
      end
   end

   // FSM: next state; a divisor forward freezes the scan position for one cycle
   always_comb begin
      state_d = state_q;
      ch_d    = ch_q;
      case (state_q)
         IDLE: begin
            if (tick) begin
               state_d = SCAN;
               ch_d    = '0;
            end
         end
         SCAN: begin
            if (!fwd) begin
               if (ch_q == LAST_CH) begin
                  state_d = IDLE;
                  ch_d    = '0;
               end else begin
                  ch_d = ch_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM: outputs and channel update
   always_comb begin
      upd      = (state_q == SCAN) & ~fwd;
      cur_new  = ramp_step(cur_sel, tgt_sel, step);
      m_cs_d   = fwd;
      m_addr_d = '0;
      m_data_d = '0;
      if (fwd) begin
         m_data_d = wr_data;
      end else if (upd && cur_new != cur_sel) begin
         m_cs_d   = 1'b1;
         m_addr_d = {1'b1, 4'(ch_q)};
         m_data_d = 32'(cur_new);
      end
      for (int i = 0; i < W; i++) begin
         cur_d[i] = cur_q[i];
         if (upd && ch_q == CHW'(i)) cur_d[i] = cur_new;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         div_q    <= '0;
         en_q     <= 1'b0;
         rate_q   <= '0;
         ovr_q    <= 1'b0;
         cnt_q    <= '0;
         m_cs_q   <= 1'b0;
         m_addr_q <= '0;
         m_data_q <= '0;
         for (int i = 0; i < W; i++) begin
            cur_q[i] <= '0;
            tgt_q[i] <= '0;
         end
      end else begin
         div_q    <= div_d;
         en_q     <= en_d;
         rate_q   <= rate_d;
         ovr_q    <= ovr_d;
         cnt_q    <= cnt_d;
         m_cs_q   <= m_cs_d;
         m_addr_q <= m_addr_d;
         m_data_q <= m_data_d;
         for (int i = 0; i < W; i++) begin
            cur_q[i] <= cur_d[i];
            tgt_q[i] <= tgt_d[i];
         end
      end
   end

   assign m_cs      = m_cs_q;
   assign m_write   = m_cs_q;
   assign m_addr    = m_addr_q;
   assign m_wr_data = m_data_q;

   always_comb begin
      rd_data = '0;
      if (cs & read) begin
         case (addr)
            5'h00:   rd_data = div_q;
            5'h01:   rd_data = {31'd0, en_q};
            5'h02:   rd_data = {8'd0, rate_q};
            5'h03:   rd_data = {30'd0, ovr_q, busy};
            default: rd_data = '0;
         endcase
`ifdef PWM_FADE_READBACK_EN
         for (int i = 0; i < W; i++) begin
            if (addr == 5'(16 + i)) rd_data = 32'(cur_q[i]);
         end
`endif
      end
   end

endmodule

// File: tb/tb_chu_pwm_fade_ctrl.sv
// Randomized bench for chu_pwm_fade_ctrl against a cycle-level behavioural model of the
// register map, interval tick, channel scan and divisor forwarding.

module tb_chu_pwm_fade_ctrl;

   localparam int W    = 6;
   localparam int R    = 10;
   localparam int DMAX = 1 << R;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        cs = 1'b0, read = 1'b0, write = 1'b0;
   logic [4:0]  addr = '0;
   logic [31:0] wr_data = '0;
   logic [31:0] rd_data;
   logic        m_cs, m_write;
   logic [4:0]  m_addr;
   logic [31:0] m_wr_data;

   int n_checks = 0;
   int n_fail   = 0;

   chu_pwm_fade_ctrl #(.W(W), .R(R)) dut (
      .clk(clk), .reset_n(reset_n), .cs(cs), .read(read), .write(write),
      .addr(addr), .wr_data(wr_data), .rd_data(rd_data),
      .m_cs(m_cs), .m_write(m_write), .m_addr(m_addr), .m_wr_data(m_wr_data)
   );

   always #5 clk = ~clk;

   // model state
   int mcur [W];
   int mtgt [W];
   int men, mint, mstep, movr, mdiv, mcnt, mpos;
   bit ecs;
   int eaddr, edata;

   int cyc_no = 0;
   int obs_t[$];
   int obs_a[$];
   int obs_d[$];
   logic [31:0] last_rd;

   task automatic check_val(string tag, logic [31:0] got, logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < W; i++) begin
         mcur[i] = 0;
         mtgt[i] = 0;
      end
      men = 0; mint = 0; mstep = 0; movr = 0; mdiv = 0; mcnt = 0; mpos = -1;
      ecs = 1'b0; eaddr = 0; edata = 0;
   endtask

   function automatic logic [31:0] model_rd(int a);
      int busy;
      busy = 0;
      for (int i = 0; i < W; i++) if (mcur[i] != mtgt[i]) busy = 1;
      case (a)
         0: return 32'(mdiv);
         1: return 32'(men);
         2: return 32'((mstep << 16) | mint);
         3: return 32'((movr << 1) | busy);
         default: ;
      endcase
`ifdef PWM_FADE_READBACK_EN
      if (a >= 16 && a < 16 + W) return 32'(mcur[a - 16]);
`endif
      return 32'd0;
   endfunction

   // Predicts state and master outputs after the next rising edge for the given inputs.
   task automatic model_step(bit c, bit w, int a, logic [31:0] d);
      bit fwd, tick;
      int st, oldpos, nv, dv;
      fwd    = c && w && (a == 0);
      tick   = (men != 0) && (mcnt == mint);
      st     = (mstep == 0) ? 1 : mstep;
      oldpos = mpos;
      ecs = 1'b0; eaddr = 0; edata = 0;
      if (fwd) begin
         ecs = 1'b1; edata = int'(d);
      end else if (oldpos >= 0) begin
         nv = mcur[oldpos];
         if (nv < mtgt[oldpos])      nv = (nv + st < mtgt[oldpos]) ? nv + st : mtgt[oldpos];
         else if (nv > mtgt[oldpos]) nv = (nv - st > mtgt[oldpos]) ? nv - st : mtgt[oldpos];
         if (nv != mcur[oldpos]) begin
            ecs = 1'b1; eaddr = 16 + oldpos; edata = nv;
         end
         mcur[oldpos] = nv;
         mpos = (oldpos == W - 1) ? -1 : oldpos + 1;
      end
      if (oldpos < 0 && tick) mpos = 0;
      mcnt = (men == 0) ? 0 : ((mcnt == mint) ? 0 : (mcnt + 1) % 65536);
      if (c && w && a == 1 && d[2]) movr = 0;
      if (oldpos >= 0 && tick) movr = 1;
      if (c && w) begin
         if (a == 0) mdiv = int'(d);
         if (a == 1) men = int'(d[0]);
         if (a == 2) begin
            mint  = int'(d[15:0]);
            mstep = int'(d[23:16]);
         end
         if (a >= 16 && a < 16 + W) begin
            dv = int'(d[R:0]);
            mtgt[a - 16] = (dv > DMAX) ? DMAX : dv;
         end
      end
   endtask

   task automatic cyc(bit c, bit r, bit w, logic [4:0] a, logic [31:0] d);
      @(negedge clk);
      cyc_no++;
      check_val("m_cs", {30'd0, m_write, m_cs}, {30'd0, ecs, ecs});
      if (ecs) begin
         check_val("m_addr", 32'(m_addr), 32'(eaddr));
         check_val("m_data", m_wr_data, 32'(edata));
      end
      if (m_cs) begin
         obs_t.push_back(cyc_no);
         obs_a.push_back(int'(m_addr));
         obs_d.push_back(int'(m_wr_data));
      end
      cs = c; read = r; write = w; addr = a; wr_data = d;
      #1;
      last_rd = rd_data;
      if (c && r) check_val("rd_data", rd_data, model_rd(int'(a)));
      model_step(c, w, int'(a), d);
   endtask

   task automatic wr(logic [4:0] a, logic [31:0] d); cyc(1'b1, 1'b0, 1'b1, a, d); endtask
   task automatic rd(logic [4:0] a); cyc(1'b1, 1'b1, 1'b0, a, 32'd0); endtask
   task automatic idle(int n); repeat (n) cyc(1'b0, 1'b0, 1'b0, 5'd0, 32'd0); endtask

   task automatic clear_log();
      obs_t.delete(); obs_a.delete(); obs_d.delete();
   endtask

   task automatic check_log(string tag, int idx, int a, int d);
      if (idx < obs_d.size()) begin
         check_val({tag, "_addr"}, 32'(obs_a[idx]), 32'(a));
         check_val({tag, "_data"}, 32'(obs_d[idx]), 32'(d));
      end else begin
         check_val({tag, "_missing"}, 32'hFFFF_FFFF, 32'(d));
      end
   endtask

   task automatic wait_pos(int p, string tag);
      int k;
      k = 0;
      while (mpos != p && k < 40) begin
         idle(1);
         k++;
      end
      check_val(tag, 32'(mpos == p), 32'd1);
   endtask

   initial begin
      int j, op, ch;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_m_cs", {30'd0, m_write, m_cs}, 32'd0);
      check_val("rst_m_addr", 32'(m_addr), 32'd0);
      check_val("rst_m_data", m_wr_data, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      for (int a = 0; a < 4; a++) begin
         rd(5'(a));
         check_val("rst_reg", last_rd, 32'd0);
      end

      // basic ramp: duty 1,2,3 on channel 0, ten cycles apart
      wr(5'h02, 32'h0001_0009);
      wr(5'h10, 32'd3);
      wr(5'h01, 32'd1);
      clear_log();
      idle(45);
      check_val("t1_nwr", 32'(obs_d.size()), 32'd3);
      check_log("t1_w0", 0, 16, 1);
      check_log("t1_w1", 1, 16, 2);
      check_log("t1_w2", 2, 16, 3);
      if (obs_t.size() == 3) begin
         check_val("t1_gap0", 32'(obs_t[1] - obs_t[0]), 32'd10);
         check_val("t1_gap1", 32'(obs_t[2] - obs_t[1]), 32'd10);
      end else begin
         check_val("t1_gaps", 32'(obs_t.size()), 32'd3);
      end
      rd(5'h03);
      check_val("t1_busy", 32'(last_rd[0]), 32'd0);

      // step clamp up and down
      wr(5'h02, 32'h0004_0009);
      wr(5'h12, 32'd10);
      clear_log();
      idle(50);
      check_val("t2_nwr_up", 32'(obs_d.size()), 32'd3);
      check_log("t2_u0", 0, 18, 4);
      check_log("t2_u1", 1, 18, 8);
      check_log("t2_u2", 2, 18, 10);
      wr(5'h12, 32'd1);
      clear_log();
      idle(50);
      check_val("t2_nwr_dn", 32'(obs_d.size()), 32'd3);
      check_log("t2_d0", 0, 18, 6);
      check_log("t2_d1", 1, 18, 2);
      check_log("t2_d2", 2, 18, 1);

      // target above full scale saturates to 1024
      wr(5'h02, 32'h00FF_0009);
      wr(5'h11, 32'h0000_07FF);
      clear_log();
      idle(70);
      check_val("t3_nwr", 32'(obs_d.size()), 32'd5);
      check_log("t3_last", obs_d.size() - 1, 17, DMAX);
      rd(5'h03);
      check_val("t3_busy", 32'(last_rd[0]), 32'd0);

      // divisor forward during channel-1 processing delays the channel-1 write
      wr(5'h10, 32'd1000);
      wr(5'h11, 32'd0);
      idle(12);
      wait_pos(1, "t4_wait");
      clear_log();
      wr(5'h00, 32'h0000_1234);
      idle(4);
      j = -1;
      for (int i = 0; i < obs_a.size(); i++) if (obs_a[i] == 0 && obs_d[i] == 32'h1234) j = i;
      check_val("t4_fwd_seen", 32'(j >= 0), 32'd1);
      if (j >= 1 && j + 1 < obs_a.size()) begin
         check_val("t4_prev_ch0", 32'(obs_a[j - 1]), 32'h10);
         check_val("t4_prev_gap", 32'(obs_t[j] - obs_t[j - 1]), 32'd1);
         check_val("t4_next_ch1", 32'(obs_a[j + 1]), 32'h11);
         check_val("t4_next_gap", 32'(obs_t[j + 1] - obs_t[j]), 32'd1);
      end else begin
         check_val("t4_context", 32'd0, 32'd1);
      end
      rd(5'h00);
      check_val("t4_div_rd", last_rd, 32'h1234);

      // overrun with a short interval, then clear
      wr(5'h01, 32'd0);
      idle(8);
      wr(5'h02, 32'h0001_0002);
      for (int i = 0; i < W; i++) wr(5'(16 + i), (mcur[i] < 512) ? 32'd1024 : 32'd0);
      wr(5'h01, 32'd1);
      idle(20);
      rd(5'h03);
      check_val("t5_ovr_set", 32'(last_rd[1]), 32'd1);
      wr(5'h01, 32'd0);
      idle(10);
      wr(5'h01, 32'd4);
      rd(5'h03);
      check_val("t5_ovr_clr", 32'(last_rd[1]), 32'd0);

      // asynchronous reset in the middle of a pass
      wr(5'h02, 32'h0001_0009);
      wr(5'h01, 32'd1);
      wait_pos(2, "t6_wait");
      @(posedge clk);
      #2;
      reset_n = 1'b0;
      cs = 1'b0; read = 1'b0; write = 1'b0; addr = '0; wr_data = '0;
      #1;
      check_val("t6_async_cs", {30'd0, m_write, m_cs}, 32'd0);
      check_val("t6_async_addr", 32'(m_addr), 32'd0);
      check_val("t6_async_data", m_wr_data, 32'd0);
      model_reset();
      @(negedge clk);
      reset_n = 1'b1;
      clear_log();
      idle(30);
      check_val("t6_no_wr", 32'(obs_d.size()), 32'd0);
      rd(5'h10);
      check_val("t6_rb_cur0", last_rd, 32'd0);

      // randomized traffic
      wr(5'h02, 32'h0003_0008);
      wr(5'h01, 32'd1);
      for (int n = 0; n < 1500; n++) begin
         op = $urandom_range(0, 99);
         if (op < 50) idle(1);
         else if (op < 60) wr(5'h00, $urandom);
         else if (op < 78) begin
            ch = $urandom_range(0, 15);
            wr(5'(16 + ch), ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 2047)));
         end else if (op < 86) rd(5'($urandom_range(0, 31)));
         else if (op < 90) wr(5'h01, $urandom & 32'h5);
         else if (op < 95) begin
            wr(5'h01, 32'd0);
            wr(5'h02, {8'd0, 8'($urandom_range(0, 40)), 16'($urandom_range(0, 12))});
            wr(5'h01, 32'd1);
         end else wr(5'($urandom_range(4, 15)), $urandom);
      end
      for (int a = 0; a < 4; a++) rd(5'(a));
      idle(2);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
